// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl
//   Forwarding-select generator for the EX-stage operand muxes. Tracks the
//   destination registers of the instructions in EX and MEM and produces the
//   one-hot selects for the two 3:1 operand muxes
//   (3'b001 regfile, 3'b010 EX/MEM result, 3'b100 MEM/WB result).
//   It also raises the load-use stall toward ID.
//
// Ports
//   clk, rst_n              pipeline clock, async active-low reset
//   hold                    global freeze; all state holds
//   flush                   kill the instruction leaving ID
//   id_valid                ID holds a real instruction
//   id_rs1/2, id_rs1/2_en   ID source indices and read enables
//   id_rd, id_we, id_load   ID destination, write enable, load flag
//   stall                   combinational load-use stall
//   ex_sel1, ex_sel2        registered one-hot operand selects for EX
//   ex_valid                EX holds a real instruction

// Per-operand select logic; one instance per source operand.
module fwd_sel_lane #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              en,
    input  logic              ex_fwd_ok,   // EX record valid and writing
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_fwd_ok,  // MEM record valid and writing
    input  logic [REG_AW-1:0] mem_rd,
    output logic [2:0]        sel,
    output logic              ex_match     // operand reads EX.rd (for stall)
);
    logic live;
    logic mem_match;

    // x0 is never forwarded: it reads as zero from the regfile.
    assign live      = en & (rs != '0);
    assign ex_match  = live & (rs == ex_rd);
    assign mem_match = live & (rs == mem_rd);

    // Younger producer (EX) wins over MEM.
    always_comb begin
        sel = 3'b001;
        if (ex_match & ex_fwd_ok)
            sel = 3'b010;
        else if (mem_match & mem_fwd_ok)
            sel = 3'b100;
    end
endmodule

module fwd_sel_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_en,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_load,
    output logic              stall,
    output logic [2:0]        ex_sel1,
    output logic [2:0]        ex_sel2,
    output logic              ex_valid
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } ex_rec_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
    } mem_rec_t;

    // vld_pipe[0] = EX valid, vld_pipe[1] = MEM valid.
    logic [1:0]                      vld_pipe;
    ex_rec_t                         ex_q;
    mem_rec_t                        mem_q;
    logic [NUM_OPS-1:0][2:0]         sel_q;
    logic [NUM_OPS-1:0][2:0]         sel_nxt;
    logic [NUM_OPS-1:0]              ex_match;
    logic [NUM_OPS-1:0][REG_AW-1:0]  op_rs;
    logic [NUM_OPS-1:0]              op_en;
    logic                            ex_fwd_ok;
    logic                            mem_fwd_ok;
    logic                            take;

    assign op_rs = {id_rs2, id_rs1};
    assign op_en = {id_rs2_en, id_rs1_en};

    assign ex_fwd_ok  = vld_pipe[0] & ex_q.we;
    assign mem_fwd_ok = vld_pipe[1] & mem_q.we;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        fwd_sel_lane #(.REG_AW(REG_AW)) u_lane (
            .rs         (op_rs[g]),
            .en         (op_en[g]),
            .ex_fwd_ok  (ex_fwd_ok),
            .ex_rd      (ex_q.rd),
            .mem_fwd_ok (mem_fwd_ok),
            .mem_rd     (mem_q.rd),
            .sel        (sel_nxt[g]),
            .ex_match   (ex_match[g])
        );
    end

    // A load in EX cannot feed ID next cycle; flush overrides the stall
    // since the dependent instruction is being killed anyway.
    assign stall = id_valid & ~flush & ex_fwd_ok & ex_q.load & (|ex_match);

    // ID instruction actually advances into EX this edge.
    assign take = id_valid & ~flush & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            ex_q     <= '0;
            mem_q    <= '0;
            sel_q    <= {NUM_OPS{3'b001}};
        end else if (!hold) begin
            vld_pipe <= {vld_pipe[0], take};
            mem_q    <= '{rd: ex_q.rd, we: ex_q.we};
            if (take) begin
                ex_q  <= '{rd: id_rd, we: id_we, load: id_load};
                sel_q <= sel_nxt;
            end else begin
                ex_q  <= '0;
                sel_q <= {NUM_OPS{3'b001}};
            end
        end
    end

    assign ex_sel1  = sel_q[0];
    assign ex_sel2  = sel_q[1];
    assign ex_valid = vld_pipe[0];
endmodule
